// File: rtl/shift_pin_sout_sync_pkg.sv
// Shared types and defaults for the TI-to-Pi serial transmitter.
package shift_pin_sout_sync_pkg;

  // Transmitter state; IDLE is only reachable through reset.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } tx_state_t;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultSyncStages = 2;

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous Pi-side strobe, with rising-edge detect.
module tipi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Synchronised level and one-clk pulse on its 0->1 transition.
  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/shift_pin_sout_sync.sv
// Parallel-in, serial-out TI-to-Pi transmitter. The TI side fills a holding register; the Pi
// side latches it into the shifter and clocks it out MSB first using asynchronous strobes.
module shift_pin_sout_sync
  import shift_pin_sout_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sclk,
  input  logic             select,
  input  logic             le,
  output logic             dout,
  output logic             parity,
  output logic             hold_full,
  output logic             busy,
  output logic             overrun,
  output logic             underrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic sclk_level_unused;
  logic sclk_rise;
  logic select_sync;
  logic select_rise_unused;
  logic le_sync;
  logic le_rise_unused;

  tipi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .async_in(sclk),
    .level   (sclk_level_unused),
    .rise    (sclk_rise)
  );

  tipi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_select (
    .clk     (clk),
    .reset   (reset),
    .async_in(select),
    .level   (select_sync),
    .rise    (select_rise_unused)
  );

  tipi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_le (
    .clk     (clk),
    .reset   (reset),
    .async_in(le),
    .level   (le_sync),
    .rise    (le_rise_unused)
  );

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             parity_q, parity_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  logic shift_evt;
  logic load_evt;

  // Qualify synchronised shift-clock rises with select; le turns a shift into a load.
  always_comb begin
    shift_evt = sclk_rise & select_sync;
    load_evt  = shift_evt & le_sync;
  end

  // Next-state logic for the holding register, shifter, FSM and sticky error flags.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;

    if (load_evt) begin
      // An empty holding register sends zeros rather than a stale byte.
      shift_d     = hold_full_q ? hold_q : '0;
      parity_d    = hold_full_q ? ^hold_q : 1'b0;
      cnt_d       = CntW'(WIDTH);
      state_d     = StShift;
      hold_full_d = 1'b0;
      if (!hold_full_q) underrun_d = 1'b1;
    end else if (shift_evt) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      if (state_q == StShift) begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // A write concurrent with a load refills the register just emptied, so no overrun.
    if (din_valid) begin
      hold_d      = din;
      hold_full_d = 1'b1;
      if (hold_full_q && !load_evt) overrun_d = 1'b1;
    end
  end

  // State registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  // Outputs are direct register views.
  always_comb begin
    dout      = shift_q[WIDTH-1];
    parity    = parity_q;
    hold_full = hold_full_q;
    busy      = (state_q == StShift);
    overrun   = overrun_q;
    underrun  = underrun_q;
  end

endmodule

// File: tb/tb_shift_pin_sout_sync.sv
// Bench for shift_pin_sout_sync: directed scenarios plus random traffic against a byte-level model.
module tb_shift_pin_sout_sync;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             sclk = 1'b0;
  logic             select = 1'b0;
  logic             le = 1'b0;
  logic             dout, parity, hold_full, busy, overrun, underrun;

  shift_pin_sout_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .sclk     (sclk),
    .select   (select),
    .le       (le),
    .dout     (dout),
    .parity   (parity),
    .hold_full(hold_full),
    .busy     (busy),
    .overrun  (overrun),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: holding byte, the byte being sent, and how many bits of it have been shifted out.
  logic [WIDTH-1:0] m_hold, m_byte;
  logic             m_full, m_loaded, m_parity, m_ovr, m_udr;
  int               m_sent;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return m_loaded && (m_sent < WIDTH);
  endfunction

  function automatic logic m_dout();
    if (!m_busy()) return 1'b0;
    return m_byte[WIDTH-1-m_sent];
  endfunction

  task automatic model_reset();
    m_hold = '0; m_byte = '0; m_full = 0; m_loaded = 0; m_parity = 0;
    m_ovr = 0; m_udr = 0; m_sent = 0;
  endtask

  task automatic model_write(input logic [WIDTH-1:0] b, input logic with_load);
    if (m_full && !with_load) m_ovr = 1;
    m_hold = b;
    m_full = 1;
  endtask

  task automatic model_shift(input logic is_load);
    if (is_load) begin
      if (!m_full) m_udr = 1;
      m_byte   = m_full ? m_hold : '0;
      m_parity = ^m_byte;
      m_sent   = 0;
      m_loaded = 1;
      m_full   = 0;
    end else if (m_busy()) begin
      m_sent++;
    end else begin
      m_udr = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, dout, m_dout());
    check({tag, ".parity"}, parity, m_parity);
    check({tag, ".hold_full"}, hold_full, m_full);
    check({tag, ".busy"}, busy, m_busy());
    check({tag, ".overrun"}, overrun, m_ovr);
    check({tag, ".underrun"}, underrun, m_udr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; din_valid = 0; sclk = 0; select = 0; le = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic write_byte(input logic [WIDTH-1:0] b);
    @(negedge clk);
    din = b; din_valid = 1;
    @(negedge clk);
    din_valid = 0;
    model_write(b, 1'b0);
  endtask

  // One Pi strobe cycle; optionally a TI write lands on the very clk the event is taken.
  task automatic pi_edge(input logic le_v, input logic sel_v, input logic wr,
                         input logic [WIDTH-1:0] b);
    @(negedge clk);
    select = sel_v; le = le_v;
    repeat (SYNC + 1) @(negedge clk);
    sclk = 1;
    if (wr) begin
      repeat (SYNC) @(negedge clk);
      din = b; din_valid = 1;
      @(negedge clk);
      din_valid = 0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (SYNC + 3) @(negedge clk);
    end
    sclk = 0;
    repeat (SYNC + 2) @(negedge clk);
    select = 0; le = 0;
    if (sel_v) model_shift(le_v);
    if (wr) model_write(b, sel_v && le_v);
  endtask

  logic [WIDTH-1:0] e;

  initial begin
    model_reset();
    do_reset();
    check_all("rst_idle");

    // Basic send of A5.
    write_byte(8'hA5);
    check("a5_full_pre", hold_full, 1'b1);
    pi_edge(1, 1, 0, '0);
    check_all("a5_load");
    check("a5_parity", parity, 1'b0);
    check("a5_full_post", hold_full, 1'b0);
    e = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("a5_dout%0d", k), dout, e[7-k]);
      check($sformatf("a5_busy%0d", k), busy, 1'b1);
      pi_edge(0, 1, 0, '0);
      check_all($sformatf("a5_shift%0d", k));
    end
    check("a5_busy_end", busy, 1'b0);
    check("a5_udr_end", underrun, 1'b0);

    // Overrun: second write before load replaces the first.
    do_reset();
    write_byte(8'h3C);
    write_byte(8'hC3);
    check("ovr_flag", overrun, 1'b1);
    pi_edge(1, 1, 0, '0);
    check_all("ovr_load");
    e = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovr_dout%0d", k), dout, e[7-k]);
      pi_edge(0, 1, 0, '0);
    end
    check_all("ovr_end");

    // Underrun: load from an empty holding register.
    do_reset();
    pi_edge(1, 1, 0, '0);
    check("udr_load_flag", underrun, 1'b1);
    check("udr_load_dout", dout, 1'b0);
    check_all("udr_load");

    // Underrun: ninth shift after FF.
    do_reset();
    write_byte(8'hFF);
    pi_edge(1, 1, 0, '0);
    for (int k = 0; k < 8; k++) pi_edge(0, 1, 0, '0);
    check("udr9_pre", underrun, 1'b0);
    pi_edge(0, 1, 0, '0);
    check("udr9_flag", underrun, 1'b1);
    check("udr9_dout", dout, 1'b0);
    check_all("udr9");

    // Write and load in the same clk.
    do_reset();
    write_byte(8'h11);
    pi_edge(1, 1, 1, 8'h22);
    check("same_full", hold_full, 1'b1);
    check("same_ovr", overrun, 1'b0);
    check_all("same_load");
    for (int k = 0; k < 8; k++) begin
      pi_edge(0, 1, 0, '0);
      check_all($sformatf("same_shift%0d", k));
    end
    pi_edge(1, 1, 0, '0);
    e = 8'h22;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("same2_dout%0d", k), dout, e[7-k]);
      pi_edge(0, 1, 0, '0);
    end

    // Re-load mid-shift.
    do_reset();
    write_byte(8'hF0);
    pi_edge(1, 1, 0, '0);
    for (int k = 0; k < 3; k++) pi_edge(0, 1, 0, '0);
    write_byte(8'h0F);
    pi_edge(1, 1, 0, '0);
    e = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rl_dout%0d", k), dout, e[7-k]);
      check($sformatf("rl_busy%0d", k), busy, 1'b1);
      pi_edge(0, 1, 0, '0);
    end
    check_all("rl_end");

    // Reset asserted mid-clock with inputs toggling.
    write_byte(8'h9B);
    write_byte(8'hE7);
    pi_edge(1, 1, 0, '0);
    @(posedge clk);
    #3;
    sclk = 1; select = 1; le = 1; din = 8'hFF; din_valid = 1;
    reset = 1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (3) @(negedge clk);
    sclk = 0; select = 0; le = 0; din_valid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    check_all("rst_release");

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      logic [WIDTH-1:0] b;
      r = $urandom_range(0, 9);
      b = WIDTH'($urandom);
      if (r <= 2) write_byte(b);
      else if (r <= 5) pi_edge(0, 1, 0, '0);
      else if (r <= 7) pi_edge(1, 1, 0, '0);
      else if (r == 8) pi_edge(1, 1, 1, b);
      else pi_edge(1'($urandom), 0, 0, '0);
      check_all($sformatf("rnd%0d_op%0d", n, r));
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
        check_all($sformatf("rnd%0d_rst", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
